// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM fetch unit and its prefetch buffer.
package rom_fetch_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } entry_t;

endpackage

// File: rtl/rom_fetch_unit_fifo.sv
// DEPTH-entry circular prefetch buffer; flush beats push/pop, push+pop when full is legal.
module fetch_fifo
    import rom_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a full buffer still accepts a word when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_fetch_unit.sv
// Sequential ROM reader feeding decode through a prefetch buffer with redirect and halt detection.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky misalign flag and word-aligns redirect targets.
module rom_fetch_unit
    import rom_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_address,
    output logic        rom_enable,
    input  logic [31:0] rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic        halted
);

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_W-1:0]      pc_q;
    logic [ADDR_W-1:0]      pc_target;
    entry_t                 head;
    entry_t                 push_entry;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   fetch;
    logic                   pop;

    assign pop        = !empty && out_ready;
    assign fetch      = (state_q == FETCH) && !redirect_valid && (!full || pop);
    assign push_entry = '{word: rom_data, pc: pc_q};

    assign rom_address = pc_q;
    assign rom_enable  = fetch;
    assign out_valid   = (count != '0);
    assign out_instr   = head.word;
    assign out_pc      = head.pc;
    assign halted      = (state_q == HALTED);

`ifdef FETCH_ALIGN_CHECK_EN
    assign pc_target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign <= 1'b1;
        end
    end
`else
    assign pc_target = redirect_pc;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = FETCH;
                FETCH:   if (fetch && (rom_data == HALT_WORD)) state_d = HALTED;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                pc_q <= pc_target;
            end else if (fetch) begin
                pc_q <= pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed and randomized checks of rom_fetch_unit against a queue-based reference model.
module tb_rom_fetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_address;
    logic        rom_enable;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic [31:0] halt_addr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rom_data = (rom_address == halt_addr) ? HALT : (rom_address ^ 32'hA5A5_0000);

    rom_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (DEPTH),
        .HALT_WORD (HALT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_address    (rom_address),
        .rom_enable     (rom_enable),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign       (misalign),
`endif
        .halted         (halted)
    );

    // Reference model: queue of delivered-to-be words, a run mode (0 idle, 1 running, 2 halted)
    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] mpc;
    int          mmode;
    bit          mclean;
    bit          mmis;

    function automatic logic [31:0] rom_model(input logic [31:0] a);
        return (a == halt_addr) ? HALT : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc    = 32'h0;
        mmode  = 0;
        mclean = 1'b1;
        mmis   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_en;
        exp_en = (mmode == 1) && !redirect_valid &&
                 (mq.size() < DEPTH || (mq.size() != 0 && out_ready));
        chk("rom_address", rom_address, mpc);
        chk("rom_enable", {31'b0, rom_enable}, {31'b0, exp_en});
        chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        chk("halted", {31'b0, halted}, {31'b0, mmode == 2});
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].word);
        end else if (mclean) begin
            chk("out_pc_empty", out_pc, 32'h0);
            chk("out_instr_empty", out_instr, 32'h0);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign", {31'b0, misalign}, {31'b0, mmis});
`endif
    endtask

    task automatic model_step();
        bit          pop_m;
        bit          en_m;
        logic [31:0] w;
        pop_m = (mq.size() != 0) && out_ready;
        if (redirect_valid) begin
            mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc % 4 != 0) mmis = 1'b1;
            mpc = redirect_pc - (redirect_pc % 4);
`else
            mpc = redirect_pc;
`endif
            mmode = 1;
        end else begin
            en_m = (mmode == 1) && (mq.size() < DEPTH || pop_m);
            if (pop_m) void'(mq.pop_front());
            if (en_m) begin
                w = rom_model(mpc);
                mq.push_back('{word: w, pc: mpc});
                mclean = 1'b0;
                if (w == HALT) mmode = 2;
                mpc = mpc + 32'd4;
            end
            if (mmode == 0 && start) mmode = 1;
        end
    endtask

    // Entered at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        if (rst) model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        halt_addr      = 32'h0000_0001;
        model_reset();
        @(negedge clk);
        cycles(2);
        rst = 1'b0;
        cycles(2);

        // streaming with consumer always ready
        start = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        cycles(8);

        // back-pressure from start: buffer fills to DEPTH and fetch stalls
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        start = 1'b1; out_ready = 1'b0;
        cycle();
        start = 1'b0;
        cycles(5);
        out_ready = 1'b1;
        cycles(4);

        // redirect while buffer is full
        out_ready = 1'b0;
        cycles(3);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; out_ready = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        cycles(4);

        // halt word at address 12, then resume via redirect
        halt_addr = 32'h0000_000C;
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        cycles(10);
        halt_addr = 32'h0000_0001;
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        cycles(3);

        // pc wrap-around
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect_valid = 1'b0;
        cycles(6);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            out_ready      = 1'($urandom_range(0, 3) != 0);
            start          = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
            if (redirect_valid && $urandom_range(0, 2) == 0)
                halt_addr = redirect_pc + 32'd4 * 32'($urandom_range(1, 10));
            cycle();
        end
        start = 1'b0; redirect_valid = 1'b0; halt_addr = 32'h0000_0001;

        // asynchronous reset with two entries buffered
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        cycle();
        redirect_valid = 1'b0;
        cycles(3);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycles(2);
        start = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        cycles(4);

`ifdef FETCH_ALIGN_CHECK_EN
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        cycle();
        redirect_valid = 1'b0;
        cycles(4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
